// File: rtl/ps2_keyboard.sv
// ps2_keyboard -- Apple-1 terminal keyboard input.
// Receives PS/2 set-2 frames, tracks make/break/shift, translates scancodes to
// uppercase Apple-1 ASCII and presents them as the KBD / KBDCR register pair.
//
// Ports:
//   clk        7 MHz system clock
//   rst_n      asynchronous active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   enable     CPU bus clock-enable strobe
//   address    0 = KBD (data), 1 = KBDCR (status)
//   r_en       CPU read strobe
//   dout       CPU read data
//   clr_screen high while F1 is held
//   reset_req  high while F12 is held
//   frame_err  one-cycle pulse on parity or framing error
//
// Receiver states:
//   state     | meaning
//   ST_IDLE   | waiting for a start bit
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the parity bit
//   ST_STOP   | checking stop bit and odd parity
module ps2_keyboard #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 7000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       enable,
    input  logic       address,
    input  logic       r_en,
    output logic [7:0] dout,
    output logic       clr_screen,
    output logic       reset_req,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_s, data_s;
    logic          clk_f, fall;
    logic [FW-1:0] filt_cnt;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg, rx_byte;
    logic          par_bit, byte_valid;
    logic [WW-1:0] wd_cnt;

    logic          shift_l, shift_r, break_pend, ext_pend;
    logic [6:0]    key_data;
    logic          key_ready, read_seen;
    logic [7:0]    ascii;
    logic          load_key, read_clr;

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
            8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
            8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
            8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
            8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
            8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
            8'h45: a = shift ? 8'h29 : 8'h30;
            8'h16: a = shift ? 8'h21 : 8'h31;
            8'h1E: a = shift ? 8'h40 : 8'h32;
            8'h26: a = shift ? 8'h23 : 8'h33;
            8'h25: a = shift ? 8'h24 : 8'h34;
            8'h2E: a = shift ? 8'h25 : 8'h35;
            8'h36: a = shift ? 8'h5E : 8'h36;
            8'h3D: a = shift ? 8'h26 : 8'h37;
            8'h3E: a = shift ? 8'h2A : 8'h38;
            8'h46: a = shift ? 8'h28 : 8'h39;
            8'h4E: a = shift ? 8'h5F : 8'h2D;
            8'h55: a = shift ? 8'h2B : 8'h3D;
            8'h4C: a = shift ? 8'h3A : 8'h3B;
            8'h52: a = shift ? 8'h22 : 8'h27;
            8'h41: a = shift ? 8'h3C : 8'h2C;
            8'h49: a = shift ? 8'h3E : 8'h2E;
            8'h4A: a = shift ? 8'h3F : 8'h2F;
            // Shifted forms of these would be lowercase-range codes, so both map alike.
            8'h54: a = 8'h5B;
            8'h5B: a = 8'h5D;
            8'h5D: a = 8'h5C;
            8'h5A: a = 8'h0D;
            8'h29: a = 8'h20;
            8'h66: a = 8'h5F;
            8'h76: a = 8'h1B;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Down-counter reloads whenever the sample agrees with the filtered level;
    // the level flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_f    <= 1'b1;
            filt_cnt <= FW'(FILTER_LEN - 1);
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == clk_f) begin
                filt_cnt <= FW'(FILTER_LEN - 1);
            end else if (filt_cnt == '0) begin
                clk_f    <= clk_s;
                filt_cnt <= FW'(FILTER_LEN - 1);
                fall     <= clk_f;
            end else begin
                filt_cnt <= filt_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            rx_byte    <= 8'h00;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            wd_cnt     <= WW'(TIMEOUT);
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                wd_cnt <= WW'(TIMEOUT);
                case (state)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= data_s;
                        state   <= ST_STOP;
                    end
                    default: begin
                        if (data_s && ^{shreg, par_bit}) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                endcase
            end else if (state != ST_IDLE) begin
                // Abandon a partial frame silently if the keyboard stops clocking.
                if (wd_cnt == '0) state <= ST_IDLE;
                else              wd_cnt <= wd_cnt - 1'b1;
            end
        end
    end

    assign ascii    = scan_to_ascii(rx_byte, shift_l | shift_r);
    assign load_key = byte_valid && !ext_pend && !break_pend && (ascii != 8'h00);
    assign read_clr = enable && r_en && !address && !read_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            clr_screen <= 1'b0;
            reset_req  <= 1'b0;
            key_data   <= 7'h00;
            key_ready  <= 1'b0;
            read_seen  <= 1'b0;
        end else begin
            if (byte_valid) begin
                if (rx_byte == 8'hF0) begin
                    break_pend <= 1'b1;
                end else if (rx_byte == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else begin
                    break_pend <= 1'b0;
                    ext_pend   <= 1'b0;
                    if (!ext_pend) begin
                        case (rx_byte)
                            8'h12:   shift_l    <= ~break_pend;
                            8'h59:   shift_r    <= ~break_pend;
                            8'h05:   clr_screen <= ~break_pend;
                            8'h07:   reset_req  <= ~break_pend;
                            default: ;
                        endcase
                    end
                end
            end
            if (load_key) key_data <= ascii[6:0];
            // A key landing on the same clk as the read-clear must not be lost.
            if (load_key)      key_ready <= 1'b1;
            else if (read_clr) key_ready <= 1'b0;
            // One clear per CPU read, however many clks the strobe spans.
            if (read_clr)               read_seen <= 1'b1;
            else if (!enable && !r_en)  read_seen <= 1'b0;
        end
    end

    // Forced to zero while reset is asserted so the bus reads 0 immediately.
    always_comb begin
        dout = 8'h00;
        if (rst_n) dout = address ? {key_ready, 7'b0} : {1'b1, key_data};
    end
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard -- directed self-checking bench for ps2_keyboard.
module tb_ps2_keyboard;
    localparam int TIMEOUT = 7000;
    localparam int HALF    = 20;

    logic       clk = 1'b0;
    logic       rst_n, ps2_clk, ps2_data, enable, address, r_en;
    logic [7:0] dout;
    logic       clr_screen, reset_req, frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int err_hi = 0;

    ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .enable(enable), .address(address), .r_en(r_en), .dout(dout),
        .clr_screen(clr_screen), .reset_req(reset_req), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err === 1'b1) err_hi++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dout(input string tag, input logic a, input logic [7:0] exp);
        address = a;
        #1;
        check(tag, dout, exp);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit((~^code) ^ bad_par);
        send_bit(1'b1);
        tick(10);
    endtask

    // Stop-bit falling edge reaches the key register 12 clks after it is driven;
    // a single-clk KBD read strobe is placed on exactly that clk.
    task automatic send_frame_strobe(input logic [7:0] code);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(~^code);
        ps2_data = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(11);
        address = 1'b0;
        enable  = 1'b1;
        r_en    = 1'b1;
        tick(1);
        enable  = 1'b0;
        r_en    = 1'b0;
        tick(HALF - 12);
        ps2_clk = 1'b1;
        tick(10);
    endtask

    task automatic cpu_read(input logic a);
        address = a;
        enable  = 1'b1;
        r_en    = 1'b1;
        tick(3);
        enable  = 1'b0;
        r_en    = 1'b0;
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        enable = 1'b0; r_en = 1'b0; address = 1'b0;
        #1;
        chk_dout("rst_kbd", 1'b0, 8'h00);
        chk_dout("rst_kbdcr", 1'b1, 8'h00);
        check("rst_clr", {7'b0, clr_screen}, 8'h00);
        check("rst_rreq", {7'b0, reset_req}, 8'h00);
        check("rst_ferr", {7'b0, frame_err}, 8'h00);
        tick(5);
        rst_n = 1'b1;
        tick(5);
        chk_dout("post_rst_kbd", 1'b0, 8'h80);

        // 'A'
        send_frame(8'h1C, 1'b0);
        chk_dout("a_kbdcr", 1'b1, 8'h80);
        chk_dout("a_kbd", 1'b0, 8'hC1);
        cpu_read(1'b1);
        chk_dout("kbdcr_read_noclr", 1'b1, 8'h80);
        cpu_read(1'b0);
        chk_dout("a_cleared", 1'b1, 8'h00);

        // shift + '1' -> '!', then release shift -> '1'
        send_frame(8'h12, 1'b0);
        chk_dout("shift_no_key", 1'b1, 8'h00);
        send_frame(8'h16, 1'b0);
        chk_dout("bang_kbd", 1'b0, 8'hA1);
        cpu_read(1'b0);
        chk_dout("bang_cleared", 1'b1, 8'h00);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        send_frame(8'h16, 1'b0);
        chk_dout("one_kbd", 1'b0, 8'hB1);
        cpu_read(1'b0);
        check("no_err_yet", err_hi[7:0], 8'd0);

        // parity error
        send_frame(8'h1C, 1'b1);
        check("par_err_width", err_hi[7:0], 8'd1);
        chk_dout("par_no_key", 1'b1, 8'h00);

        // partial frame abandoned by watchdog, then Enter
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        tick(TIMEOUT + 10);
        send_frame(8'h5A, 1'b0);
        check("timeout_no_err", err_hi[7:0], 8'd1);
        chk_dout("enter_kbd", 1'b0, 8'h8D);
        chk_dout("enter_kbdcr", 1'b1, 8'h80);
        cpu_read(1'b0);

        // F1 / F12 hold and release
        send_frame(8'h05, 1'b0);
        check("f1_make", {7'b0, clr_screen}, 8'h01);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h05, 1'b0);
        check("f1_break", {7'b0, clr_screen}, 8'h00);
        send_frame(8'h07, 1'b0);
        check("f12_make", {7'b0, reset_req}, 8'h01);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h07, 1'b0);
        check("f12_break", {7'b0, reset_req}, 8'h00);
        chk_dout("fkeys_no_key", 1'b1, 8'h00);

        // extended keys ignored, unmapped ignored
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h5A, 1'b0);
        chk_dout("ext_ignored", 1'b1, 8'h00);
        send_frame(8'h83, 1'b0);
        chk_dout("unmapped_ignored", 1'b1, 8'h00);

        // overrun overwrites data, ready stays set
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1A, 1'b0);
        chk_dout("overrun_kbd", 1'b0, 8'hDA);
        chk_dout("overrun_kbdcr", 1'b1, 8'h80);

        // reset mid-frame with shift held, F1 held and a key pending
        send_frame(8'h12, 1'b0);
        send_frame(8'h05, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        rst_n = 1'b0;
        #1;
        chk_dout("midrst_kbd", 1'b0, 8'h00);
        chk_dout("midrst_kbdcr", 1'b1, 8'h00);
        check("midrst_clr", {7'b0, clr_screen}, 8'h00);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        chk_dout("after_rst_kbd", 1'b0, 8'h80);
        send_frame(8'h29, 1'b0);
        chk_dout("space_kbd", 1'b0, 8'hA0);
        chk_dout("space_kbdcr", 1'b1, 8'h80);

        // new key on the same clk as a read-clear: load wins; shift was reset
        send_frame_strobe(8'h16);
        chk_dout("simul_kbdcr", 1'b1, 8'h80);
        chk_dout("simul_kbd", 1'b0, 8'hB1);
        cpu_read(1'b0);
        chk_dout("final_cleared", 1'b1, 8'h00);
        check("final_err_count", err_hi[7:0], 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Keyboard input side of the Apple-1 terminal; complements the display (output) block.
- Receives PS/2 frames, tracks make/break/shift, translates set-2 scancodes to uppercase Apple-1 ASCII.
- Presents the result to the CPU as the KBD / KBDCR register pair.
- Also drives the display's clr_screen input and a system reset request from dedicated keys.

Parameters:
- FILTER_LEN, 8, consecutive identical synchronized samples required to accept a new ps2_clk level (deglitch).
- TIMEOUT, 7000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned (~1 ms at 7 MHz).

Ports:
- clk  in  1  7 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from keyboard (asynchronous).
- ps2_data  in  1  raw PS/2 data from keyboard (asynchronous).
- enable  in  1  CPU bus clock-enable strobe.
- address  in  1  0 = KBD (data), 1 = KBDCR (status).
- r_en  in  1  active-high CPU read strobe.
- dout  out  8  CPU read data.
- clr_screen  out  1  high while F1 is held; feeds display clr_screen.
- reset_req  out  1  high while F12 is held.
- frame_err  out  1  one-cycle pulse on parity or framing error.

Behaviour:
- Reset (rst_n low, async): receiver IDLE; shift_l, shift_r, break_pend and ext_pend cleared; key_data=0, key_ready=0; dout=0, clr_screen=0, reset_req=0, frame_err=0. A frame in progress is discarded.
- Input conditioning:
  - ps2_clk and ps2_data pass through 2-flop synchronizers.
  - Filtered clock changes level only after FILTER_LEN equal samples; it resets high.
  - Data is sampled on the filtered clock's falling edge.
- Receiver FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: on a falling edge, data=0 (start bit) goes to DATA with bit count 0; data=1 stays in IDLE with no error.
  - DATA: shift in LSB first; after 8 bits go to PARITY.
  - PARITY: latch the bit, go to STOP.
  - STOP: the frame is valid if stop=1 and the 8 data bits plus parity have odd weight. Valid frame: one-cycle byte_valid to the decoder. Invalid frame: frame_err pulses 1 cycle and the byte is dropped. Either way return to IDLE.
  - Watchdog: in any state other than IDLE, a counter clears on every falling edge. When it reaches TIMEOUT, go to IDLE silently with no frame_err.
- Decoder, acting on byte_valid:
  - 0xF0: set break_pend.
  - 0xE0: set ext_pend.
  - Any other byte: process as a key, then clear break_pend and ext_pend.
  - ext_pend set: key ignored entirely.
  - 0x12 / 0x59: shift_l / shift_r = ~break_pend.
  - 0x05 (F1): clr_screen = ~break_pend.
  - 0x07 (F12): reset_req = ~break_pend.
  - Break of any other key: no effect.
  - Make of any other key: look up ASCII. Nonzero -> key_data <= ascii[6:0], key_ready <= 1. Zero (unmapped) -> ignored.
- ASCII map, with shift = shift_l | shift_r:
  - Letters always uppercase (0x1C->'A' 0x41, 0x1A->'Z' 0x5A).
  - Digits and US punctuation follow shift (0x16: '1' 0x31 / '!' 0x21; 0x1E: '2' 0x32 / '@' 0x40; 0x4C: ';' / ':'; 0x55: '=' / '+').
  - 0x5A Enter->0x0D, 0x29 Space->0x20, 0x66 Backspace->0x5F, 0x76 Esc->0x1B.
  - No lowercase codes are ever produced.
- CPU interface:
  - dout is combinational from address: address=0 -> {1'b1, key_data}; address=1 -> {key_ready, 7'b0}.
  - Read-clear: key_ready clears on the first clk where enable & r_en & address==0.
  - A read_seen flag blocks further clears until ~enable & ~r_en, so a single CPU read spanning several clks clears exactly once.
  - Reads of KBDCR have no side effects.
- Overrun: a new key while key_ready=1 overwrites key_data; key_ready stays 1.
- Simultaneous new-key load and read-clear in the same cycle: the load wins (key_ready=1, new data).
- Reset mid-frame or with a key pending: everything returns to reset values; the keyboard's next start bit begins a fresh frame.

Test Plan:
- Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) -> key_ready=1; KBDCR dout=0x80; KBD dout=0xC1.
- Sequence 0x12, 0x16, then read KBD -> dout=0xA1 ('!'), then KBDCR=0x00. Repeat after F0 12 -> 0xB1 ('1').
- Frame 0x1C with parity 1 -> frame_err pulses exactly 1 cycle; key_ready stays 0.
- 4 falling edges then silence for TIMEOUT+10 cycles, then a full frame 0x5A -> no frame_err; KBD=0x8D.
- 05 -> clr_screen=1 held; F0 05 -> clr_screen=0; no key_ready. E0 75 -> ignored.
- Assert rst_n=0 after 5 bits of a frame -> all outputs 0 immediately. Next full 0x29 frame -> KBD=0xA0. Key arriving on the same clk as a read strobe -> key_ready remains 1.
